// File: rtl/prior_req_capture_4.sv
// Request capture stage ahead of the 4-to-2 priority encoder: edge detect, sticky pending, masked snapshot, overrun count.
// Optional REQ_SYNC_EN inserts a 2-flop synchroniser on req_in before edge detection.
module prior_req_capture_4 #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [WIDTH-1:0] input_data,
    output logic             data_valid,
    output logic [OVR_W-1:0] overrun_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_req_d;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [OVR_W-1:0] r_ovr;

    logic [WIDTH-1:0] w_req_s;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pending_next;
    logic [WIDTH-1:0] w_snapshot;
    logic             w_load;
    logic             w_ack_accept;
    logic             w_overrun;

`ifdef REQ_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= req_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_req_s = r_sync2;
`else
    assign w_req_s = req_in;
`endif

    assign w_edge     = w_req_s & ~r_req_d;
    assign w_snapshot = r_pending & mask_in;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ack_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_snapshot) begin
                    w_load       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ack_valid) begin
                    w_ack_accept = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Out-of-range ack indices match no bit, so nothing is cleared for them.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_clr[i] = w_ack_accept && (ack_idx == IDX_W'(i));
        end
    end

    // A new edge on a bit being cleared this cycle wins and is not an overrun.
    assign w_pending_next = (r_pending & ~w_clr) | w_edge;
    assign w_overrun      = |(w_edge & r_pending & ~w_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= '0;
        end else begin
            r_req_d   <= w_req_s;
            r_pending <= w_pending_next;
            if (w_load) begin
                r_data  <= w_snapshot;
                r_valid <= 1'b1;
            end else if (w_ack_accept) begin
                r_valid <= 1'b0;
            end
            if (w_overrun && (r_ovr != {OVR_W{1'b1}})) begin
                r_ovr <= r_ovr + 1'b1;
            end
        end
    end

    assign input_data  = r_data;
    assign data_valid  = r_valid;
    assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_prior_req_capture_4.sv
// Directed self-checking bench for prior_req_capture_4; expected values are hand-derived from the behaviour.
// Honours REQ_SYNC_EN through the LAT latency constant.
module tb_prior_req_capture_4;

`ifdef REQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask_in;
    logic       ack_valid;
    logic [1:0] ack_idx;
    logic [3:0] input_data;
    logic       data_valid;
    logic [7:0] overrun_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    prior_req_capture_4 #(.WIDTH(4), .IDX_W(2), .OVR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .mask_in     (mask_in),
        .ack_valid   (ack_valid),
        .ack_idx     (ack_idx),
        .input_data  (input_data),
        .data_valid  (data_valid),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack_valid = 1'b1;
        ack_idx   = idx;
        tick(1);
        ack_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_in = 4'b0000; mask_in = 4'b1111; ack_valid = 1'b0; ack_idx = 2'd0;
        tick(2);
        testsRun++;
        if (input_data !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_data got %b want 0000", input_data); end
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", data_valid); end
        testsRun++;
        if (overrun_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_ovr got %0d want 0", overrun_cnt); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        req_in = 4'b0100;
        tick(LAT - 1);
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_early got %b want 0", data_valid); end
        tick(1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b0100) begin
            testsFailed++; $display("[TB] FAIL basic_snap got v=%b d=%b want v=1 d=0100", data_valid, input_data);
        end
        do_ack(2'd2);
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_ack got %b want 0", data_valid); end
        tick(4);
        testsRun++;
        if (data_valid !== 1'b0 || input_data !== 4'b0100) begin
            testsFailed++; $display("[TB] FAIL basic_noretrig got v=%b d=%b want v=0 d=0100", data_valid, input_data);
        end
    endtask

    task automatic test_hold_freeze;
        req_in = 4'b0000;
        tick(LAT);
        req_in = 4'b0100;
        tick(LAT);
        req_in = 4'b0101;
        tick(LAT + 1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b0100) begin
            testsFailed++; $display("[TB] FAIL hold_frozen got v=%b d=%b want v=1 d=0100", data_valid, input_data);
        end
        do_ack(2'd2);
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_idle_gap got %b want 0", data_valid); end
        tick(1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b0001) begin
            testsFailed++; $display("[TB] FAIL hold_next got v=%b d=%b want v=1 d=0001", data_valid, input_data);
        end
        do_ack(2'd0);
        req_in = 4'b0000;
        tick(LAT + 1);
    endtask

    task automatic test_mask;
        mask_in = 4'b1110;
        req_in  = 4'b0001;
        tick(LAT + 1);
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL mask_gated got %b want 0", data_valid); end
        do_ack(2'd0);
        mask_in = 4'b1111;
        tick(1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b0001) begin
            testsFailed++; $display("[TB] FAIL mask_release got v=%b d=%b want v=1 d=0001", data_valid, input_data);
        end
        do_ack(2'd0);
        req_in = 4'b0000;
        tick(LAT + 1);
        testsRun++;
        if (overrun_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL mask_ovr got %0d want 0", overrun_cnt); end
    endtask

    task automatic test_set_wins;
        req_in = 4'b0010;
        tick(LAT);
        req_in = 4'b0000;
        tick(1);
        req_in = 4'b0010;
        tick(LAT - 2);
        do_ack(2'd1);
        testsRun++;
        if (data_valid !== 1'b0 || overrun_cnt !== 8'd0) begin
            testsFailed++; $display("[TB] FAIL setwins_ack got v=%b ovr=%0d want v=0 ovr=0", data_valid, overrun_cnt);
        end
        tick(1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b0010) begin
            testsFailed++; $display("[TB] FAIL setwins_retained got v=%b d=%b want v=1 d=0010", data_valid, input_data);
        end
        do_ack(2'd1);
        req_in = 4'b0000;
        tick(LAT + 1);
    endtask

    task automatic test_overrun;
        req_in = 4'b1000; tick(1);
        req_in = 4'b0000; tick(1);
        req_in = 4'b1000; tick(1);
        tick(LAT - 2);
        testsRun++;
        if (overrun_cnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL ovr_one got %0d want 1", overrun_cnt); end
        for (int n = 2; n <= 200; n++) begin
            req_in = 4'b0000; tick(1);
            req_in = 4'b1000; tick(1);
        end
        tick(LAT - 2);
        testsRun++;
        if (overrun_cnt !== 8'd200) begin testsFailed++; $display("[TB] FAIL ovr_200 got %0d want 200", overrun_cnt); end
        for (int n = 201; n <= 300; n++) begin
            req_in = 4'b0000; tick(1);
            req_in = 4'b1000; tick(1);
        end
        tick(LAT - 2);
        testsRun++;
        if (overrun_cnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL ovr_sat got %0d want 255", overrun_cnt); end
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b1000) begin
            testsFailed++; $display("[TB] FAIL ovr_hold got v=%b d=%b want v=1 d=1000", data_valid, input_data);
        end
    endtask

    task automatic test_reset_mid_hold;
        req_in = 4'b1000;
        rst = 1'b1;
        tick(2);
        testsRun++;
        if (data_valid !== 1'b0 || input_data !== 4'b0000 || overrun_cnt !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL rst_hold got v=%b d=%b ovr=%0d want v=0 d=0000 ovr=0", data_valid, input_data, overrun_cnt);
        end
        rst = 1'b0;
        tick(LAT - 1);
        testsRun++;
        if (data_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_redetect_early got %b want 0", data_valid); end
        tick(1);
        testsRun++;
        if (data_valid !== 1'b1 || input_data !== 4'b1000) begin
            testsFailed++; $display("[TB] FAIL rst_redetect got v=%b d=%b want v=1 d=1000", data_valid, input_data);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold_freeze;
        test_mask;
        test_set_wins;
        test_overrun;
        test_reset_mid_hold;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
